// File: rtl/im_pkg.sv
// rtl/im_pkg.sv - shared widths and state/tag types for the instruction memory arbiter
package im_pkg;
  localparam int IM_ADDR_W = 11;
  localparam int IM_DATA_W = 16;

  typedef enum logic {BOOT, RUN} arb_state_t;
  typedef enum logic [1:0] {TAG_NONE, TAG_FETCH, TAG_LOAD} resp_tag_t;
endpackage

// File: rtl/im_arb_core.sv
// rtl/im_arb_core.sv - per-cycle grant logic with bounded loader wait counter
module im_arb_core #(
  parameter int MAX_WAIT = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       run,
  input  logic       fetch_req,
  input  logic       ld_req,
  output logic       fetch_gnt,
  output logic       ld_gnt,
  output logic [3:0] wait_cnt
);
  localparam logic [3:0] WAIT_LIM = 4'(MAX_WAIT);

  logic [3:0] wait_d;

  always_comb begin
    fetch_gnt = 1'b0;
    ld_gnt    = 1'b0;
    if (!run) begin
      ld_gnt = ld_req;
    end else if (ld_req && (wait_cnt == WAIT_LIM)) begin
      ld_gnt = 1'b1;
    end else if (fetch_req) begin
      fetch_gnt = 1'b1;
    end else begin
      ld_gnt = ld_req;
    end
  end

  // Counts consecutive refused loader cycles; saturates at the forced-grant limit.
  always_comb begin
    wait_d = wait_cnt;
    if (!run || !ld_req || ld_gnt) begin
      wait_d = 4'd0;
    end else if (wait_cnt < WAIT_LIM) begin
      wait_d = wait_cnt + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt <= 4'd0;
    end else begin
      wait_cnt <= wait_d;
    end
  end
endmodule

// File: rtl/im_arbiter.sv
// rtl/im_arbiter.sv - shares the single-port instruction memory between CPU fetch and loader
module im_arbiter
  import im_pkg::*;
#(
  parameter int ADDR_W   = IM_ADDR_W,
  parameter int DATA_W   = IM_DATA_W,
  parameter int MAX_WAIT = 4,
  parameter int BOOT_EN  = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic              fetch_gnt,
  output logic              fetch_vld,
  output logic [DATA_W-1:0] fetch_instr,
  output logic              cpu_stall,
  input  logic              ld_req,
  input  logic              ld_we,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_wdata,
  output logic              ld_gnt,
  output logic              ld_rvld,
  output logic [DATA_W-1:0] ld_rdata,
  input  logic              ld_done,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd_en,
  output logic              mem_wr_en,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);
  localparam arb_state_t RESET_STATE = (BOOT_EN != 0) ? BOOT : RUN;

  arb_state_t        state_q, state_d;
  resp_tag_t         tag_q, tag_d;
  logic [DATA_W-1:0] instr_q, rdata_q;
  logic              run;
  logic [3:0]        wait_cnt;

  assign run = (state_q == RUN);

  im_arb_core #(.MAX_WAIT(MAX_WAIT)) u_core (
    .clk       (clk),
    .rst_n     (rst_n),
    .run       (run),
    .fetch_req (fetch_req),
    .ld_req    (ld_req),
    .fetch_gnt (fetch_gnt),
    .ld_gnt    (ld_gnt),
    .wait_cnt  (wait_cnt)
  );

  always_comb begin
    state_d   = state_q;
    cpu_stall = 1'b1;
    if (state_q == BOOT) begin
      if (ld_done) state_d = RUN;
    end else begin
      cpu_stall = fetch_req & ~fetch_gnt;
    end
  end

  always_comb begin
    tag_d = TAG_NONE;
    if (fetch_gnt) begin
      tag_d = TAG_FETCH;
    end else if (ld_gnt && !ld_we) begin
      tag_d = TAG_LOAD;
    end
  end

  // The tag marks which requester owns the data the IM returns this cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RESET_STATE;
      tag_q   <= TAG_NONE;
      instr_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      tag_q   <= tag_d;
      if (tag_q == TAG_FETCH) instr_q <= mem_rdata;
      if (tag_q == TAG_LOAD)  rdata_q <= mem_rdata;
    end
  end

  assign fetch_vld   = (tag_q == TAG_FETCH);
  assign ld_rvld     = (tag_q == TAG_LOAD);
  assign fetch_instr = fetch_vld ? mem_rdata : instr_q;
  assign ld_rdata    = ld_rvld ? mem_rdata : rdata_q;

  assign mem_addr  = fetch_gnt ? fetch_addr : (ld_gnt ? ld_addr : '0);
  assign mem_rd_en = fetch_gnt | (ld_gnt & ~ld_we);
  assign mem_wr_en = ld_gnt & ld_we;
  assign mem_wdata = mem_wr_en ? ld_wdata : '0;
endmodule

// File: tb/tb_im_arbiter.sv
// tb/tb_im_arbiter.sv - directed and randomized checks of im_arbiter against a reference model
module tb_im_arbiter;
  localparam int AW = 11;
  localparam int DW = 16;
  localparam int MAXW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          fetch_req = 1'b0;
  logic [AW-1:0] fetch_addr = '0;
  logic          fetch_gnt, fetch_vld, cpu_stall;
  logic [DW-1:0] fetch_instr;
  logic          ld_req = 1'b0, ld_we = 1'b0, ld_done = 1'b0;
  logic [AW-1:0] ld_addr = '0;
  logic [DW-1:0] ld_wdata = '0;
  logic          ld_gnt, ld_rvld;
  logic [DW-1:0] ld_rdata;
  logic [AW-1:0] mem_addr;
  logic          mem_rd_en, mem_wr_en;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;

  int checks = 0;
  int failures = 0;

  im_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_WAIT(MAXW), .BOOT_EN(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_gnt(fetch_gnt),
    .fetch_vld(fetch_vld), .fetch_instr(fetch_instr), .cpu_stall(cpu_stall),
    .ld_req(ld_req), .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
    .ld_gnt(ld_gnt), .ld_rvld(ld_rvld), .ld_rdata(ld_rdata), .ld_done(ld_done),
    .mem_addr(mem_addr), .mem_rd_en(mem_rd_en), .mem_wr_en(mem_wr_en),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] init_word(input int a);
    return DW'((a * 40503) ^ 16'h5A3C);
  endfunction

  // Instruction memory: contents seeded on the first edge, one-cycle read latency.
  logic [DW-1:0] im [0:(1<<AW)-1];
  logic          im_init = 1'b0;
  always @(posedge clk) begin
    if (!im_init) begin
      for (int i = 0; i < (1 << AW); i++) im[i] <= init_word(i);
      im_init <= 1'b1;
    end else begin
      if (mem_wr_en) im[mem_addr] <= mem_wdata;
      if (mem_rd_en) mem_rdata <= im[mem_addr];
    end
  end

  // Reference model state
  logic [DW-1:0] ref_mem [0:(1<<AW)-1];
  bit            m_run;
  int            m_refused;
  bit            e_fvld, e_lvld;
  logic [DW-1:0] e_instr, e_rdata;
  bit            last_ef, last_eld;
  logic          obs_fgnt, obs_lgnt, obs_stall;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_run = 1'b0;
    m_refused = 0;
    e_fvld = 1'b0;
    e_lvld = 1'b0;
    e_instr = '0;
    e_rdata = '0;
    last_ef = 1'b0;
    last_eld = 1'b0;
  endtask

  // One clock: compare at the falling edge, then advance the model across the rising edge.
  task automatic step();
    bit            ef, eld, estall;
    logic [AW-1:0] ea;
    @(negedge clk);
    ef = 1'b0;
    eld = 1'b0;
    if (!m_run) eld = ld_req;
    else if (ld_req && m_refused >= MAXW) eld = 1'b1;
    else if (fetch_req) ef = 1'b1;
    else eld = ld_req;
    estall = !m_run || (fetch_req && !ef);
    ea = ef ? fetch_addr : (eld ? ld_addr : '0);
    chk("fetch_gnt", fetch_gnt, ef);
    chk("ld_gnt", ld_gnt, eld);
    chk("cpu_stall", cpu_stall, estall);
    chk("mem_addr", mem_addr, ea);
    chk("mem_rd_en", mem_rd_en, ef || (eld && !ld_we));
    chk("mem_wr_en", mem_wr_en, eld && ld_we);
    chk("mem_wdata", mem_wdata, (eld && ld_we) ? ld_wdata : '0);
    chk("fetch_vld", fetch_vld, e_fvld);
    chk("ld_rvld", ld_rvld, e_lvld);
    chk("fetch_instr", fetch_instr, e_instr);
    chk("ld_rdata", ld_rdata, e_rdata);
    chk("wait_cnt", dut.u_core.wait_cnt, m_refused);
    obs_fgnt = fetch_gnt;
    obs_lgnt = ld_gnt;
    obs_stall = cpu_stall;
    @(posedge clk);
    if (rst_n) begin
      e_fvld = ef;
      e_lvld = eld && !ld_we;
      if (ef) e_instr = ref_mem[fetch_addr];
      if (eld && !ld_we) e_rdata = ref_mem[ld_addr];
      if (eld && ld_we) ref_mem[ld_addr] = ld_wdata;
      if (!m_run || !ld_req || eld) m_refused = 0;
      else if (m_refused < MAXW) m_refused++;
      if (!m_run && ld_done) m_run = 1'b1;
      last_ef = ef;
      last_eld = eld;
    end
    #1;
  endtask

  task automatic idle();
    fetch_req = 1'b0;
    ld_req = 1'b0;
    ld_we = 1'b0;
    ld_done = 1'b0;
  endtask

  bit g_ld [0:5];
  bit g_st [0:5];
  bit g_f  [0:5];

  initial begin
    for (int i = 0; i < (1 << AW); i++) ref_mem[i] = init_word(i);
    model_reset();
    step();
    step();
    rst_n = 1'b1;

    // Boot load while the CPU keeps asking for address 0
    fetch_req = 1'b1; fetch_addr = 11'h000;
    ld_req = 1'b1; ld_we = 1'b1; ld_addr = 11'h000; ld_wdata = 16'hA5A5;
    step();
    chk("boot_fgnt0", obs_fgnt, 1'b0);
    ld_addr = 11'h7FF; ld_wdata = 16'h1234;
    step();
    chk("boot_stall", obs_stall, 1'b1);
    ld_we = 1'b0;
    step();
    ld_req = 1'b0;
    chk("boot_rvld", ld_rvld, 1'b1);
    chk("boot_rdata", ld_rdata, 16'h1234);
    ld_done = 1'b1;
    step();
    ld_done = 1'b0;
    step();
    chk("run_fgnt", obs_fgnt, 1'b1);
    chk("run_stall", obs_stall, 1'b0);
    fetch_req = 1'b0;
    chk("run_fvld", fetch_vld, 1'b1);
    chk("run_instr", fetch_instr, 16'hA5A5);
    step();

    // Loader starvation bound under continuous fetch
    fetch_req = 1'b1;
    ld_req = 1'b1; ld_we = 1'b0; ld_addr = 11'h7FF;
    for (int t = 0; t < 6; t++) begin
      fetch_addr = 11'(11'h100 + t);
      if (t == 5) ld_req = 1'b0;
      step();
      g_ld[t] = obs_lgnt; g_st[t] = obs_stall; g_f[t] = obs_fgnt;
    end
    for (int t = 0; t < 4; t++) chk("starve_refused", g_ld[t], 1'b0);
    chk("starve_forced", g_ld[4], 1'b1);
    chk("starve_stall", g_st[4], 1'b1);
    chk("starve_resume", g_f[5], 1'b1);
    chk("starve_wait_clr", dut.u_core.wait_cnt, 4'd0);

    // Back-to-back fetches
    for (int t = 0; t < 3; t++) begin
      fetch_addr = 11'(11'h010 + t);
      step();
    end
    fetch_req = 1'b0;
    step();

    // Fetch read then loader read-back on the next cycle
    fetch_req = 1'b1; fetch_addr = 11'h020;
    step();
    fetch_req = 1'b0;
    ld_req = 1'b1; ld_we = 1'b0; ld_addr = 11'h000;
    step();
    ld_req = 1'b0;
    step();
    step();

    // Reset lands while a fetch read is in flight
    fetch_req = 1'b1; fetch_addr = 11'h030;
    step();
    idle();
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("rst_fvld", fetch_vld, 1'b0);
    chk("rst_instr", fetch_instr, '0);
    chk("rst_stall", cpu_stall, 1'b1);
    chk("rst_mem_rd", mem_rd_en, 1'b0);
    step();
    step();
    rst_n = 1'b1;
    step();
    chk("rst_boot_state", dut.state_q, 1'b0);
    ld_done = 1'b1;
    step();
    ld_done = 1'b0;

    // Randomized traffic in RUN; a refused requester holds its request
    for (int n = 0; n < 600; n++) begin
      if (!(fetch_req && !last_ef)) begin
        fetch_req = ($urandom_range(0, 99) < 60);
        fetch_addr = AW'($urandom);
      end
      if (!(ld_req && !last_eld)) begin
        ld_req = ($urandom_range(0, 99) < 45);
        ld_we = $urandom_range(0, 1) == 1;
        ld_addr = AW'($urandom_range(0, 31));
        ld_wdata = DW'($urandom);
      end
      ld_done = ($urandom_range(0, 99) < 5);
      step();
    end
    idle();
    step();
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
